// File: rtl/alu_out_pkg.sv
// Shared types and default sizes for the ALU_out result driver.
package alu_out_pkg;

    localparam int unsigned ALU_OUT_RESULT_WIDTH_DEF = 16;
    localparam int unsigned ALU_OUT_FIFO_DEPTH_DEF   = 4;
    localparam int unsigned ALU_OUT_GAP_WIDTH_DEF    = 4;

    typedef enum logic [1:0] {
        ALU_OUT_IDLE,
        ALU_OUT_DRIVE,
        ALU_OUT_GAP
    } alu_out_drv_state_e;

endpackage

// File: rtl/alu_out_fifo.sv
// Synchronous result buffer; push is ignored when full and pop is ignored when empty.
module alu_out_fifo
    import alu_out_pkg::*;
#(
    parameter  int unsigned WIDTH = ALU_OUT_RESULT_WIDTH_DEF,
    parameter  int unsigned DEPTH = ALU_OUT_FIFO_DEPTH_DEF,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full_c,
    output logic             empty_c,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;
    assign rdata_c = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/alu_out_result_driver.sv
// Producer end of the ALU_out bus: buffers core results and emits one done pulse per result.
// Optional result parity output enabled by defining ALU_OUT_PARITY_EN.
module alu_out_result_driver
    import alu_out_pkg::*;
#(
    parameter  int unsigned ALU_OUT_RESULT_WIDTH = ALU_OUT_RESULT_WIDTH_DEF,
    parameter  int unsigned FIFO_DEPTH           = ALU_OUT_FIFO_DEPTH_DEF,
    parameter  int unsigned GAP_WIDTH            = ALU_OUT_GAP_WIDTH_DEF,
    localparam int unsigned CNT_W                = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            drv_en,
    input  logic [GAP_WIDTH-1:0]            gap_cycles,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ALU_OUT_RESULT_WIDTH-1:0] in_result,
    output logic                            done,
    output logic [ALU_OUT_RESULT_WIDTH-1:0] result,
    output logic [CNT_W-1:0]                fifo_count
`ifdef ALU_OUT_PARITY_EN
    ,
    output logic                            result_par
`endif
);

    localparam int unsigned RW = ALU_OUT_RESULT_WIDTH;

    alu_out_drv_state_e state_q, state_d;
    logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
    logic                 done_q, done_d;
    logic [RW-1:0]        result_q, result_d;
    logic [RW-1:0]        head_c;
    logic                 full_c, empty_c;
    logic                 pop_c;

    alu_out_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid && in_ready),
        .pop     (pop_c),
        .wdata   (in_result),
        .rdata_c (head_c),
        .full_c  (full_c),
        .empty_c (empty_c),
        .count   (fifo_count)
    );

    assign in_ready = !full_c;

    // Next-state: a pop always coincides with loading result and raising done.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;
        result_d  = result_q;
        pop_c     = 1'b0;
        unique case (state_q)
            ALU_OUT_IDLE: begin
                if (!empty_c && drv_en) begin
                    pop_c    = 1'b1;
                    done_d   = 1'b1;
                    result_d = head_c;
                    state_d  = ALU_OUT_DRIVE;
                end
            end
            ALU_OUT_DRIVE: begin
                if (gap_cycles == '0) begin
                    if (!empty_c && drv_en) begin
                        pop_c    = 1'b1;
                        done_d   = 1'b1;
                        result_d = head_c;
                    end else begin
                        state_d = ALU_OUT_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cycles - GAP_WIDTH'(1);
                    state_d   = ALU_OUT_GAP;
                end
            end
            ALU_OUT_GAP: begin
                if (gap_cnt_q == '0) state_d = ALU_OUT_IDLE;
                else                 gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
            end
            default: state_d = ALU_OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ALU_OUT_IDLE;
            gap_cnt_q <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

`ifdef ALU_OUT_PARITY_EN
    logic par_q, par_d;

    // result only moves on a pop, so parity of the next result tracks it exactly.
    always_comb begin
        par_d = ^result_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par_q <= 1'b0;
        else      par_q <= par_d;
    end

    assign result_par = par_q;
`endif

endmodule

// File: tb/tb_alu_out_result_driver.sv
// Randomized and directed bench for alu_out_result_driver against a queue-based reference model.
module tb_alu_out_result_driver;

    localparam int unsigned RW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned GW    = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          drv_en = 1'b0;
    logic [GW-1:0] gap_cycles = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [RW-1:0] in_result = '0;
    logic          done;
    logic [RW-1:0] result;
    logic [CW-1:0] fifo_count;
`ifdef ALU_OUT_PARITY_EN
    logic          result_par;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state: accepted-but-not-yet-driven results, plus pulse spacing bookkeeping.
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] exp_v;
    logic [RW-1:0] last_result = '0;
    logic [GW-1:0] gap_at_prev = '0;
    int            low_run = 0;
    bit            have_prev = 1'b0;
    bit            prev_pending = 1'b0;
    bit            drv_steady = 1'b1;

    always #5 clk = ~clk;

    alu_out_result_driver #(
        .ALU_OUT_RESULT_WIDTH (RW),
        .FIFO_DEPTH           (DEPTH),
        .GAP_WIDTH            (GW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .drv_en     (drv_en),
        .gap_cycles (gap_cycles),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .done       (done),
        .result     (result),
        .fifo_count (fifo_count)
`ifdef ALU_OUT_PARITY_EN
        ,
        .result_par (result_par)
`endif
    );

    // Accepted handshakes enter the model at the clock edge.
    always @(posedge clk) begin
        if (rst && in_valid && in_ready) exp_q.push_back(in_result);
    end

    // Bus monitor: every pulse must carry the oldest accepted result with legal spacing.
    always @(negedge clk) begin
        if (rst) begin
            drv_steady = drv_steady && (drv_en === 1'b1);
            if (done === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_pulse result=%h expected no pulse", result);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (result !== exp_v) begin
                        failures++;
                        $display("FAIL scoreboard result=%h expected=%h", result, exp_v);
                    end
                end
                checks++;
                if (drv_en !== 1'b1) begin
                    failures++;
                    $display("FAIL pop_while_disabled drv_en=%b expected=1", drv_en);
                end
                if (have_prev && gap_at_prev != '0) begin
                    checks++;
                    if ((prev_pending && drv_steady) ? (low_run != int'(gap_at_prev) + 1)
                                                     : (low_run < int'(gap_at_prev) + 1)) begin
                        failures++;
                        $display("FAIL gap_spacing low=%0d gap=%0d pending=%0d", low_run, gap_at_prev, prev_pending);
                    end
                end else if (have_prev && prev_pending && drv_steady) begin
                    checks++;
                    if (low_run != 0) begin
                        failures++;
                        $display("FAIL back_to_back low=%0d expected=0", low_run);
                    end
                end
                have_prev    = 1'b1;
                prev_pending = (exp_q.size() > 0);
                gap_at_prev  = gap_cycles;
                drv_steady   = 1'b1;
                low_run      = 0;
                last_result  = result;
            end else begin
                low_run++;
                checks++;
                if (result !== last_result) begin
                    failures++;
                    $display("FAIL result_hold result=%h expected=%h", result, last_result);
                end
            end
            checks++;
            if (fifo_count !== CW'(exp_q.size())) begin
                failures++;
                $display("FAIL fifo_count count=%0d expected=%0d", fifo_count, exp_q.size());
            end
            checks++;
            if (in_ready !== (exp_q.size() < int'(DEPTH))) begin
                failures++;
                $display("FAIL in_ready ready=%b occupancy=%0d", in_ready, exp_q.size());
            end
`ifdef ALU_OUT_PARITY_EN
            checks++;
            if (result_par !== ^result) begin
                failures++;
                $display("FAIL parity_track par=%b expected=%b", result_par, ^result);
            end
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_model();
        exp_q.delete();
        last_result = '0;
        have_prev   = 1'b0;
        low_run     = 0;
        drv_steady  = 1'b1;
    endtask

    task automatic test_reset();
        bit seen;
        int cnt;
        // Power-on reset values.
        #3;
        checks += 4;
        if (done !== 1'b0)      begin failures++; $display("FAIL por_done done=%b expected=0", done); end
        if (result !== '0)      begin failures++; $display("FAIL por_result result=%h expected=0", result); end
        if (fifo_count !== '0)  begin failures++; $display("FAIL por_count count=%0d expected=0", fifo_count); end
        if (in_ready !== 1'b1)  begin failures++; $display("FAIL por_ready ready=%b expected=1", in_ready); end
        tick();
        rst = 1'b1;
        tick();
        // Queue four, then reset during the first pulse with three still buffered.
        drv_en = 1'b0;
        gap_cycles = GW'(3);
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_result = RW'($urandom_range(1, 16'hFFFF));
            tick();
        end
        in_valid = 1'b0;
        drv_en   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL reset_wait_pulse timeout expected a pulse"); end
        rst = 1'b0;
        #1;
        clear_model();
        checks += 4;
        if (done !== 1'b0)      begin failures++; $display("FAIL rst_done done=%b expected=0", done); end
        if (result !== '0)      begin failures++; $display("FAIL rst_result result=%h expected=0", result); end
        if (fifo_count !== '0)  begin failures++; $display("FAIL rst_count count=%0d expected=0", fifo_count); end
        if (in_ready !== 1'b1)  begin failures++; $display("FAIL rst_ready ready=%b expected=1", in_ready); end
`ifdef ALU_OUT_PARITY_EN
        checks++;
        if (result_par !== 1'b0) begin failures++; $display("FAIL rst_par par=%b expected=0", result_par); end
`endif
        tick();
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 0) begin failures++; $display("FAIL rst_discard pulses=%0d expected=0", cnt); end
        gap_cycles = '0;
    endtask

    task automatic test_single();
        gap_cycles = '0;
        drv_en     = 1'b1;
        in_valid   = 1'b1;
        in_result  = 16'h1234;
        tick();
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL single_latency done=%b expected=0", done); end
        tick();
        checks += 2;
        if (done !== 1'b1)       begin failures++; $display("FAIL single_done done=%b expected=1", done); end
        if (result !== 16'h1234) begin failures++; $display("FAIL single_result result=%h expected=1234", result); end
        tick();
        checks += 2;
        if (done !== 1'b0)       begin failures++; $display("FAIL single_one_cycle done=%b expected=0", done); end
        if (result !== 16'h1234) begin failures++; $display("FAIL single_hold result=%h expected=1234", result); end
    endtask

    task automatic test_back_to_back();
        gap_cycles = '0;
        drv_en     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                in_valid  = 1'b1;
                in_result = RW'(i + 1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            checks += 2;
            if (done !== ((i >= 1 && i <= 4) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL burst_done step=%0d done=%b", i, done);
            end
            if (i >= 1 && result !== RW'(i > 4 ? 4 : i)) begin
                failures++;
                $display("FAIL burst_result step=%0d result=%h expected=%h", i, result, (i > 4 ? 4 : i));
            end
        end
    endtask

    task automatic test_gap();
        int            t[$];
        logic [RW-1:0] v[$];
        drv_en     = 1'b0;
        gap_cycles = GW'(3);
        in_valid   = 1'b1;
        in_result  = 16'h000A;
        tick();
        in_result  = 16'h000B;
        tick();
        in_valid = 1'b0;
        drv_en   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) begin
                t.push_back(i);
                v.push_back(result);
            end
        end
        checks++;
        if (t.size() != 2) begin
            failures++;
            $display("FAIL gap_pulse_count pulses=%0d expected=2", t.size());
        end else begin
            checks += 3;
            if (v[0] !== 16'h000A) begin failures++; $display("FAIL gap_first result=%h expected=000a", v[0]); end
            if (v[1] !== 16'h000B) begin failures++; $display("FAIL gap_second result=%h expected=000b", v[1]); end
            if (t[1] - t[0] != 5)  begin failures++; $display("FAIL gap_period period=%0d expected=5", t[1] - t[0]); end
        end
        gap_cycles = '0;
    endtask

    task automatic test_full();
        int            t[$];
        logic [RW-1:0] v[$];
        bit            acc;
        drv_en     = 1'b0;
        gap_cycles = '0;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_result = RW'(16'h0100 + i);
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL full_ready_early idx=%0d ready=%b expected=1", i, in_ready); end
            tick();
        end
        in_result = 16'h0104;
        tick();
        tick();
        checks += 2;
        if (in_ready !== 1'b0)     begin failures++; $display("FAIL full_ready ready=%b expected=0", in_ready); end
        if (fifo_count !== CW'(4)) begin failures++; $display("FAIL full_count count=%0d expected=4", fifo_count); end
        drv_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
            if (done === 1'b1) begin
                t.push_back(i);
                v.push_back(result);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (t.size() != 5) begin
            failures++;
            $display("FAIL full_drain pulses=%0d expected=5", t.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (v[i] !== RW'(16'h0100 + i) || t[i] != t[0] + i) begin
                    failures++;
                    $display("FAIL full_order idx=%0d result=%h cyc=%0d expected=%h", i, v[i], t[i], 16'h0100 + i);
                end
            end
        end
    endtask

`ifdef ALU_OUT_PARITY_EN
    task automatic test_parity();
        logic [RW-1:0] vals [2];
        logic          pars [2];
        bit            seen;
        vals[0] = 16'h0007; pars[0] = 1'b1;
        vals[1] = 16'h0003; pars[1] = 1'b0;
        drv_en     = 1'b1;
        gap_cycles = '0;
        for (int k = 0; k < 2; k++) begin
            in_valid  = 1'b1;
            in_result = vals[k];
            tick();
            in_valid = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 8 && !seen; i++) begin
                tick();
                if (done === 1'b1) seen = 1'b1;
            end
            checks++;
            if (!seen || result_par !== pars[k]) begin
                failures++;
                $display("FAIL parity val=%h seen=%0d par=%b expected=%b", vals[k], seen, result_par, pars[k]);
            end
        end
    endtask
`endif

    task automatic test_random();
        bit drained;
        for (int p = 0; p < 6; p++) begin
            gap_cycles = (p == 0) ? GW'(0) : GW'($urandom_range(0, 3));
            drv_en     = 1'b1;
            for (int c = 0; c < 80; c++) begin
                in_valid  = ($urandom_range(0, 2) != 0);
                in_result = RW'($urandom);
                if (p == 4) drv_en = ($urandom_range(0, 3) != 0);
                tick();
            end
            in_valid = 1'b0;
            drv_en   = 1'b1;
            drained  = 1'b0;
            for (int c = 0; c < 200 && !drained; c++) begin
                tick();
                if (exp_q.size() == 0 && done === 1'b0) drained = 1'b1;
            end
            checks++;
            if (!drained) begin
                failures++;
                $display("FAIL random_drain phase=%0d left=%0d expected=0", p, exp_q.size());
            end
            for (int c = 0; c < 8; c++) tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_full();
`ifdef ALU_OUT_PARITY_EN
        test_parity();
`endif
        test_random();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
